// File: rtl/pipe_ctrl_unit.sv
// Pipelined IF/ID/EX control unit with per-stage decode
// and counter-based load-use stall insertion.
module pipe_ctrl_unit #(
  parameter int OPW        = 2,
  parameter int RAW        = 3,
  parameter int LOAD_STALL = 1,
  parameter int OP_ALU     = 0,
  parameter int OP_IMM     = 1,
  parameter int OP_LD      = 2,
  parameter int OP_JMP     = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_valid,
  input  logic [OPW-1:0] if_opcode,
  input  logic [RAW-1:0] if_rd,
  input  logic [RAW-1:0] if_rs,
  output logic           pc_jump_sel,
  output logic           pc_stall,
  output logic           id_valid,
  output logic           exe_ctrl,
  output logic           ex_valid,
  output logic           mem_read,
  output logic           writeReg,
  output logic [RAW-1:0] wb_rd
);

  typedef enum logic [1:0] {
    C_ALU, C_IMM, C_LD, C_JMP
  } cls_t;

  localparam logic [OPW-1:0] K_ALU = OPW'(OP_ALU);
  localparam logic [OPW-1:0] K_IMM = OPW'(OP_IMM);
  localparam logic [OPW-1:0] K_LD  = OPW'(OP_LD);
  localparam logic [OPW-1:0] K_JMP = OPW'(OP_JMP);
  localparam logic [3:0]     S_INI = 4'(LOAD_STALL - 1);

  function automatic cls_t dec(input logic [OPW-1:0] op);
    cls_t c;
    c = C_ALU;
    unique case (1'b1)
      (op == K_ALU): c = C_ALU;
      (op == K_IMM): c = C_IMM;
      (op == K_LD):  c = C_LD;
      (op == K_JMP): c = C_JMP;
      default:       c = C_ALU;
    endcase
    return c;
  endfunction

  logic           id_v;
  logic [OPW-1:0] id_op;
  logic [RAW-1:0] id_rd;
  logic [RAW-1:0] id_rs;
  logic           ex_v;
  logic [OPW-1:0] ex_op;
  logic [RAW-1:0] ex_rd;
  logic [3:0]     stall_cnt;

  cls_t if_cls;
  cls_t id_cls;
  cls_t ex_cls;
  logic hz;
  logic stall;

  assign if_cls = dec(if_opcode);
  assign id_cls = dec(id_op);
  assign ex_cls = dec(ex_op);

  // Jumps in ID never read a register, so they cannot create a hazard
  assign hz = id_v && id_cls != C_JMP
           && ex_v && ex_cls == C_LD
           && ex_rd != '0 && ex_rd == id_rs;

  assign stall = hz || stall_cnt != 4'd0;

  assign pc_stall    = ~rst & stall;
  assign pc_jump_sel = ~rst & if_valid & (if_cls == C_JMP) & ~stall;
  assign id_valid    = ~rst & id_v;
  assign ex_valid    = ~rst & ex_v;
  assign exe_ctrl    = ~rst & id_v & (id_cls == C_IMM);
  assign mem_read    = ~rst & ex_v & (ex_cls == C_LD);
  assign writeReg    = ~rst & ex_v & (ex_cls != C_JMP);
  assign wb_rd       = (~rst & ex_v) ? ex_rd : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_v      <= 1'b0;
      id_op     <= '0;
      id_rd     <= '0;
      id_rs     <= '0;
      ex_v      <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      stall_cnt <= 4'd0;
    end else begin
      if (!stall) begin
        id_v  <= if_valid;
        id_op <= if_opcode;
        id_rd <= if_rd;
        id_rs <= if_rs;
        ex_v  <= id_v;
        ex_op <= id_op;
        ex_rd <= id_rd;
      end else begin
        ex_v  <= 1'b0;
      end
      if (hz && stall_cnt == 4'd0)
        stall_cnt <= S_INI;
      else if (stall_cnt != 4'd0)
        stall_cnt <= stall_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: two instances (LOAD_STALL 1 and 3)
// with an EX-stage scoreboard of expected write/load/rd results.
module tb_pipe_ctrl_unit;

  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] IMM = 2'd1;
  localparam logic [1:0] LD  = 2'd2;
  localparam logic [1:0] JMP = 2'd3;

  logic       clk = 1'b0;
  logic       rst  [2];
  logic       iv   [2];
  logic [1:0] iop  [2];
  logic [2:0] ird  [2];
  logic [2:0] irs  [2];
  logic       pjs  [2];
  logic       ps   [2];
  logic       idv  [2];
  logic       ec   [2];
  logic       exv  [2];
  logic       mr   [2];
  logic       wr   [2];
  logic [2:0] wbrd [2];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst[0]),
    .if_valid(iv[0]), .if_opcode(iop[0]),
    .if_rd(ird[0]), .if_rs(irs[0]),
    .pc_jump_sel(pjs[0]), .pc_stall(ps[0]),
    .id_valid(idv[0]), .exe_ctrl(ec[0]),
    .ex_valid(exv[0]), .mem_read(mr[0]),
    .writeReg(wr[0]), .wb_rd(wbrd[0])
  );

  pipe_ctrl_unit #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst[1]),
    .if_valid(iv[1]), .if_opcode(iop[1]),
    .if_rd(ird[1]), .if_rs(irs[1]),
    .pc_jump_sel(pjs[1]), .pc_stall(ps[1]),
    .id_valid(idv[1]), .exe_ctrl(ec[1]),
    .ex_valid(exv[1]), .mem_read(mr[1]),
    .writeReg(wr[1]), .wb_rd(wbrd[1])
  );

  typedef struct packed {
    logic       w;
    logic       m;
    logic [2:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_);
    checks++;
    assert (obs === exp_) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_);
    end
  endtask

  function automatic void push(input int d, input logic w,
                               input logic m, input logic [2:0] rd);
    exp_t e;
    e = '{w: w, m: m, rd: rd};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // EX-stage monitor: every live EX instruction pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst[0] && exv[0]) begin
      if (q0.size() == 0) chk("sb0_extra", 1, 0);
      else begin
        e = q0.pop_front();
        chk("sb0_wr", wr[0], e.w);
        chk("sb0_mr", mr[0], e.m);
        chk("sb0_rd", wbrd[0], e.rd);
      end
    end
    if (!rst[1] && exv[1]) begin
      if (q1.size() == 0) chk("sb1_extra", 1, 0);
      else begin
        e = q1.pop_front();
        chk("sb1_wr", wr[1], e.w);
        chk("sb1_mr", mr[1], e.m);
        chk("sb1_rd", wbrd[1], e.rd);
      end
    end
  end

  // Present one IF slot, holding it through any stall (bounded)
  task automatic drive(input int d, input logic v,
                       input logic [1:0] op,
                       input logic [2:0] rd, input logic [2:0] rs,
                       output int st, output logic js0,
                       output logic js, output logic eco,
                       output logic wro);
    iv[d] = v; iop[d] = op; ird[d] = rd; irs[d] = rs;
    st = 0;
    @(negedge clk);
    js0 = pjs[d];
    while (ps[d] && st < 20) begin
      st++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    js = pjs[d]; eco = ec[d]; wro = wr[d];
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  int   st;
  logic j0, j, e, w;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; iop[i] = ALU;
      ird[i] = 3'd0; irs[i] = 3'd0;
    end
    iv[0] = 1'b1; iop[0] = JMP;

    // T1 reset with a jump waiting in IF
    repeat (3) begin
      @(negedge clk);
      chk("t1_pjs", pjs[0], 0);
      chk("t1_ps", ps[0], 0);
      chk("t1_ec", ec[0], 0);
      chk("t1_mr", mr[0], 0);
      chk("t1_wr", wr[0], 0);
      chk("t1_wbrd", wbrd[0], 0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    drive(0, 1, JMP, 0, 0, st, j0, j, e, w);
    chk("t1_jump_first", j0, 1);
    chk("t1_st", st, 0);
    push(0, 0, 0, 0);

    // T2 ALU, IMM, JMP stream
    drive(0, 1, ALU, 1, 0, st, j0, j, e, w);
    chk("t2_alu_st", st, 0);
    push(0, 1, 0, 1);
    drive(0, 1, IMM, 2, 0, st, j0, j, e, w);
    chk("t2_imm_ec", e, 0);
    push(0, 1, 0, 2);
    drive(0, 1, JMP, 0, 0, st, j0, j, e, w);
    chk("t2_jmp_ec", e, 1);
    chk("t2_jmp_js", j, 1);
    chk("t2_jmp_st", st, 0);
    push(0, 0, 0, 0);
    repeat (2) drive(0, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t2_flush_st", st, 0);

    // T3 load-use, one stall cycle, jump waits in IF
    drive(0, 1, LD, 3, 0, st, j0, j, e, w);
    push(0, 1, 1, 3);
    drive(0, 1, ALU, 1, 3, st, j0, j, e, w);
    chk("t3_alu_st", st, 0);
    push(0, 1, 0, 1);
    drive(0, 1, JMP, 0, 0, st, j0, j, e, w);
    chk("t3_stall_len", st, 1);
    chk("t3_js_stalled", j0, 0);
    chk("t3_js_release", j, 1);
    chk("t3_bubble_wr", w, 0);
    push(0, 0, 0, 0);
    repeat (2) drive(0, 0, ALU, 0, 0, st, j0, j, e, w);

    // T5 load to r0 then reader of r0; load then jump
    drive(0, 1, LD, 0, 0, st, j0, j, e, w);
    push(0, 1, 1, 0);
    drive(0, 1, ALU, 1, 0, st, j0, j, e, w);
    push(0, 1, 0, 1);
    drive(0, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t5_r0_st", st, 0);
    drive(0, 0, ALU, 0, 0, st, j0, j, e, w);
    drive(0, 1, LD, 4, 0, st, j0, j, e, w);
    push(0, 1, 1, 4);
    drive(0, 1, JMP, 0, 4, st, j0, j, e, w);
    chk("t5_jmp_js", j, 1);
    push(0, 0, 0, 0);
    drive(0, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t5_jmp_st", st, 0);
    drive(0, 0, ALU, 0, 0, st, j0, j, e, w);

    // T4 three-cycle stall on the second instance
    drive(1, 1, LD, 5, 0, st, j0, j, e, w);
    push(1, 1, 1, 5);
    drive(1, 1, IMM, 1, 5, st, j0, j, e, w);
    chk("t4_imm_st", st, 0);
    push(1, 1, 0, 1);
    drive(1, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t4_stall_len", st, 3);
    chk("t4_ec_held", e, 1);
    chk("t4_bubble_wr", w, 0);
    drive(1, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t4_no_restall", st, 0);
    drive(1, 0, ALU, 0, 0, st, j0, j, e, w);

    // T6 reset in the second stall cycle
    drive(1, 1, LD, 5, 0, st, j0, j, e, w);
    push(1, 1, 1, 5);
    drive(1, 1, IMM, 1, 5, st, j0, j, e, w);
    push(1, 1, 0, 1);
    @(negedge clk);
    chk("t6_stall_c1", ps[1], 1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    void'(q1.pop_back());
    @(negedge clk);
    chk("t6_ps_in_rst", ps[1], 0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("t6_ps_after", ps[1], 0);
    chk("t6_exv_after", exv[1], 0);
    chk("t6_idv_after", idv[1], 0);
    drive(1, 0, ALU, 0, 0, st, j0, j, e, w);
    chk("t6_no_residual", st, 0);
    drive(1, 0, ALU, 0, 0, st, j0, j, e, w);

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
